sub_bytes_serial: RTL and testbench

Byte-serial AES SubBytes stage with a single shared S-box datapath, one byte per clock. It sits directly upstream of the ShiftRow stage. Its registered `outputValid` pulse drives ShiftRow's `startTransition` input, and its `outputData` drives ShiftRow's `inputData`. It trades 16 cycles of latency for one S-box instance instead of sixteen.

---
 rtl/sub_bytes_serial.sv | 111 +++++++++++
 tb/tb_sub_bytes_serial.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sub_bytes_serial.sv
// sub_bytes_serial: byte-serial AES SubBytes, one shared S-box, one byte per clock.
// Define AES_INV_SUB_BYTES_EN to add the decrypt port and the inverse S-box.
module sub_bytes_serial (
    input  logic         clk,
    input  logic         rst,
`ifdef AES_INV_SUB_BYTES_EN
    input  logic         decrypt,
`endif
    input  logic [127:0] inputData,
    input  logic         inputValid,
    output logic         inputReady,
    output logic [127:0] outputData,
    output logic         outputValid
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t       state, state_next;
    logic [3:0]   idx;
    logic [127:0] work;
    logic [7:0]   cur, sub;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? t : 8'h00);
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the field inverse and maps 0 to 0 without a special case
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] p, s;
        s = gmul(x, x);
        p = s;
        for (int i = 0; i < 6; i++) begin
            s = gmul(s, s);
            p = gmul(p, s);
        end
        return p;
    endfunction

    function automatic logic [7:0] aff(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    assign cur = work[{~idx, 3'b000} +: 8];

`ifdef AES_INV_SUB_BYTES_EN
    logic       dec;
    logic [7:0] g;

    function automatic logic [7:0] inv_aff(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    always_comb begin
        g   = ginv(dec ? inv_aff(cur) : cur);
        sub = dec ? g : aff(g);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)
            dec <= 1'b0;
        else if (state == IDLE && inputValid)
            dec <= decrypt;
`else
    assign sub = aff(ginv(cur));
`endif

    assign inputReady = (state == IDLE);

    always_comb begin
        state_next = state;
        if (state == IDLE)
            state_next = inputValid ? RUN : IDLE;
        else
            state_next = (idx == 4'hf) ? IDLE : RUN;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_next;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idx         <= 4'd0;
            work        <= '0;
            outputData  <= '0;
            outputValid <= 1'b0;
        end else begin
            outputValid <= 1'b0;
            if (state == IDLE) begin
                if (inputValid) begin
                    work <= inputData;
                    idx  <= 4'd0;
                end
            end else begin
                work[{~idx, 3'b000} +: 8] <= sub;
                idx <= idx + 4'd1;
                if (idx == 4'hf) begin
                    outputData  <= {work[127:8], sub};
                    outputValid <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_sub_bytes_serial.sv
// tb_sub_bytes_serial: directed self-checking bench for sub_bytes_serial.
module tb_sub_bytes_serial;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] inputData = '0;
    logic         inputValid = 1'b0;
    logic         inputReady;
    logic [127:0] outputData;
    logic         outputValid;
`ifdef AES_INV_SUB_BYTES_EN
    logic         decrypt = 1'b0;
`endif
    int n_chk = 0;
    int n_fail = 0;

    sub_bytes_serial dut (
        .clk(clk),
        .rst(rst),
`ifdef AES_INV_SUB_BYTES_EN
        .decrypt(decrypt),
`endif
        .inputData(inputData),
        .inputValid(inputValid),
        .inputReady(inputReady),
        .outputData(outputData),
        .outputValid(outputValid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // accept at E0, expect the pulse exactly at E16 and data held afterwards
    task automatic run(input string tag, input logic [127:0] d, input logic [127:0] e);
        inputData  = d;
        inputValid = 1'b1;
        step();
        inputValid = 1'b0;
        chk({tag, " ready after E0"}, 128'(inputReady), 128'(0));
        for (int k = 1; k <= 15; k++) begin
            step();
            chk($sformatf("%s valid E%0d", tag, k), 128'(outputValid), 128'(0));
            chk($sformatf("%s ready E%0d", tag, k), 128'(inputReady), 128'(0));
        end
        step();
        chk({tag, " valid E16"}, 128'(outputValid), 128'(1));
        chk({tag, " data E16"}, outputData, e);
        chk({tag, " ready E16"}, 128'(inputReady), 128'(1));
        step();
        chk({tag, " valid E17"}, 128'(outputValid), 128'(0));
        chk({tag, " data held"}, outputData, e);
    endtask

    initial begin
        repeat (3) step();
        chk("rst data", outputData, 128'h0);
        chk("rst valid", 128'(outputValid), 128'(0));
        chk("rst ready", 128'(inputReady), 128'(1));
        rst = 1'b0;
        repeat (3) step();
        chk("idle data", outputData, 128'h0);
        chk("idle valid", 128'(outputValid), 128'(0));
        chk("idle ready", 128'(inputReady), 128'(1));

        run("fips", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230);
        run("zeros", {16{8'h00}}, {16{8'h63}});
        run("ones", {16{8'hff}}, {16{8'h16}});
        run("b53", {8'h53, {15{8'h01}}}, {8'hed, {15{8'h7c}}});

        // back-to-back with inputValid held high throughout
        inputData  = {16{8'hff}};
        inputValid = 1'b1;
        step();
        inputData = {16{8'h00}};
        for (int k = 1; k <= 34; k++) begin
            step();
            chk($sformatf("b2b valid E%0d", k), 128'(outputValid), 128'((k == 16 || k == 33) ? 1 : 0));
            if (k == 16) begin
                chk("b2b data1", outputData, {16{8'h16}});
                chk("b2b ready E16", 128'(inputReady), 128'(1));
            end
            if (k == 17) chk("b2b ready E17", 128'(inputReady), 128'(0));
            if (k == 33) chk("b2b data2", outputData, {16{8'h63}});
        end
        inputValid = 1'b0;
        repeat (20) step();

        // reset in the middle of a block
        inputData  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        inputValid = 1'b1;
        step();
        inputValid = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        #1;
        chk("abort data", outputData, 128'h0);
        chk("abort valid", 128'(outputValid), 128'(0));
        chk("abort ready", 128'(inputReady), 128'(1));
        step();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("abort quiet %0d", k), 128'(outputValid), 128'(0));
        end
        chk("abort data stays", outputData, 128'h0);
        run("after rst", {8'h53, {15{8'h01}}}, {8'hed, {15{8'h7c}}});

`ifdef AES_INV_SUB_BYTES_EN
        decrypt = 1'b1;
        run("inv fips", 128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        run("inv 63", {16{8'h63}}, 128'h0);
        inputData  = {16{8'h63}};
        inputValid = 1'b1;
        step();
        inputValid = 1'b0;
        repeat (7) step();
        decrypt = 1'b0;
        repeat (9) step();
        chk("toggle valid", 128'(outputValid), 128'(1));
        chk("toggle data", outputData, 128'h0);
        decrypt = 1'b0;
        run("fwd again", {16{8'h00}}, {16{8'h63}});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
